muldiv_iter: RTL and testbench

MULDIV_ITER -- requirements
Module: muldiv_iter

---
 rtl/muldiv_iter.sv | 286 ++++++++++++++++++++++++++++
 tb/tb_muldiv_iter.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_iter.sv
// ---------------------------------------------------------------------------
// muldiv_iter -- iterative multiply / multiply-accumulate / divide unit that
// owns the architectural HI/LO register pair.
//
// Optional feature macro: MULDIV_DIV_EN
//   defined   : DIV/DIVU run a 32-step restoring divider (DIV and DFIX states).
//   undefined : DIV/DIVU are treated like NCARE; no divider hardware exists.
//
// Ports
//   clk            single clock, all registers update on its rising edge
//   reset          synchronous, active-high; overrides every other input
//   start          request an operation; only taken while idle
//   funct          operation selector (selector::muldiv_funct_t)
//   rs, rt         32-bit operands, captured on the accepting edge
//   flush          abort whatever is in flight; result is discarded
//   wr_hi, wr_lo   MTHI/MTLO write enables (idle and start low only)
//   wdata          MTHI/MTLO data
//   hi, lo         architectural HI/LO
//   busy           high in every state except IDLE
//   done           one-cycle pulse in the cycle hi/lo first show a result
//
// Handshake: start is a request sampled on a rising edge; it is accepted
// when the unit is idle, flush is low and funct names a supported
// operation. busy acts as the inverse of "ready": while it is high any
// start is dropped (no queueing). done marks the single cycle in which the
// new result is visible on hi/lo.
//
// The result is driven onto hi/lo combinationally during the final state
// (ACC or DFIX) and committed to the registers on the edge that leaves it,
// so a flush or reset arriving in that last cycle still suppresses both
// the visible result and the write.
// ---------------------------------------------------------------------------
package selector;
  typedef enum logic [3:0] {
    NCARE = 4'd0,
    MULT  = 4'd1,
    MULTU = 4'd2,
    MADD  = 4'd3,
    MADDU = 4'd4,
    MSUB  = 4'd5,
    MSUBU = 4'd6,
    DIV   = 4'd7,
    DIVU  = 4'd8
  } muldiv_funct_t;
endpackage

module muldiv_iter (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  selector::muldiv_funct_t funct,
  input  logic [31:0]             rs,
  input  logic [31:0]             rt,
  input  logic                    flush,
  input  logic                    wr_hi,
  input  logic                    wr_lo,
  input  logic [31:0]             wdata,
  output logic [31:0]             hi,
  output logic [31:0]             lo,
  output logic                    busy,
  output logic                    done
);

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_MUL  = 3'd1;
  localparam logic [2:0] ST_ACC  = 3'd2;
`ifdef MULDIV_DIV_EN
  localparam logic [2:0] ST_DIV  = 3'd3;
  localparam logic [2:0] ST_DFIX = 3'd4;
`endif

  // state is kept as a plainly named register so checkers can bind to it
  logic [2:0]              state;
  selector::muldiv_funct_t op;
  logic [31:0]             a_r;
  logic [31:0]             b_r;
  logic [31:0]             hi_r;
  logic [31:0]             lo_r;
  logic [63:0]             prod_r;

  logic                    start_ok;
  logic                    accept;
  logic                    mul_sgn;
  logic [63:0]             ext_a;
  logic [63:0]             ext_b;
  logic [63:0]             prod;
  logic [63:0]             acc_res;
  logic                    commit;
  logic [63:0]             res;

  function automatic logic is_mul_op(input selector::muldiv_funct_t f);
    case (f)
      selector::MULT, selector::MULTU,
      selector::MADD, selector::MADDU,
      selector::MSUB, selector::MSUBU: is_mul_op = 1'b1;
      default:                         is_mul_op = 1'b0;
    endcase
  endfunction

`ifdef MULDIV_DIV_EN
  function automatic logic is_div_op(input selector::muldiv_funct_t f);
    is_div_op = (f == selector::DIV) || (f == selector::DIVU);
  endfunction

  logic [4:0]  cnt;
  logic        div_init;   // first DIV cycle loads magnitudes
  logic        neg_q;
  logic        neg_r;
  logic        dvz;
  logic [31:0] rem_r;
  logic [31:0] quo_r;      // dividend bits shift out as quotient bits shift in
  logic [31:0] dvs_r;
  logic        div_sgn;
  logic [31:0] mag_a;
  logic [31:0] mag_b;
  logic [32:0] shift;
  logic [32:0] diff;
  logic [31:0] q_fix;
  logic [31:0] r_fix;

  always_comb begin
    div_sgn = (op == selector::DIV);
    mag_a   = (div_sgn && a_r[31]) ? (32'd0 - a_r) : a_r;
    mag_b   = (div_sgn && b_r[31]) ? (32'd0 - b_r) : b_r;
    // one restoring step: bring down the next dividend bit, try to subtract
    shift   = {rem_r, quo_r[31]};
    diff    = shift - {1'b0, dvs_r};
    if (dvz) begin
      // divide by zero does not trap: all-ones quotient, dividend in HI
      q_fix = 32'hFFFF_FFFF;
      r_fix = a_r;
    end else begin
      q_fix = neg_q ? (32'd0 - quo_r) : quo_r;
      r_fix = neg_r ? (32'd0 - rem_r) : rem_r;
    end
  end
`endif

  always_comb begin
    start_ok = is_mul_op(funct);
`ifdef MULDIV_DIV_EN
    if (is_div_op(funct)) start_ok = 1'b1;
`endif
  end

  // flush beats start in the same idle cycle
  assign accept = (state == ST_IDLE) && start && !flush && start_ok;

  // Sign- or zero-extend to 64 bits; the low 64 bits of the product are
  // then correct for both signed and unsigned operands.
  always_comb begin
    mul_sgn = (op == selector::MULT) || (op == selector::MADD) ||
              (op == selector::MSUB);
    ext_a   = {{32{mul_sgn & a_r[31]}}, a_r};
    ext_b   = {{32{mul_sgn & b_r[31]}}, b_r};
    prod    = ext_a * ext_b;
  end

  always_comb begin
    case (op)
      selector::MADD, selector::MADDU: acc_res = {hi_r, lo_r} + prod_r;
      selector::MSUB, selector::MSUBU: acc_res = {hi_r, lo_r} - prod_r;
      default:                         acc_res = prod_r;
    endcase
  end

  always_comb begin
    commit = 1'b0;
    res    = {hi_r, lo_r};
    if (!reset && !flush) begin
      case (state)
        ST_ACC: begin
          commit = 1'b1;
          res    = acc_res;
        end
`ifdef MULDIV_DIV_EN
        ST_DFIX: begin
          commit = 1'b1;
          res    = {r_fix, q_fix};
        end
`endif
        default: ;
      endcase
    end
  end

  assign hi   = res[63:32];
  assign lo   = res[31:0];
  assign done = commit;
  assign busy = (state != ST_IDLE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_IDLE;
      op       <= selector::NCARE;
      a_r      <= 32'd0;
      b_r      <= 32'd0;
      hi_r     <= 32'd0;
      lo_r     <= 32'd0;
      prod_r   <= 64'd0;
`ifdef MULDIV_DIV_EN
      cnt      <= 5'd0;
      div_init <= 1'b0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      dvz      <= 1'b0;
      rem_r    <= 32'd0;
      quo_r    <= 32'd0;
      dvs_r    <= 32'd0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            a_r <= rs;
            b_r <= rt;
            op  <= funct;
`ifdef MULDIV_DIV_EN
            if (is_div_op(funct)) begin
              state    <= ST_DIV;
              div_init <= 1'b1;
              cnt      <= 5'd0;
            end else
`endif
            state <= ST_MUL;
          end else if (!start) begin
            if (wr_hi) hi_r <= wdata;
            if (wr_lo) lo_r <= wdata;
          end
        end

        ST_MUL: begin
          if (flush) begin
            state <= ST_IDLE;
          end else begin
            prod_r <= prod;
            state  <= ST_ACC;
          end
        end

        ST_ACC: begin
          if (commit) {hi_r, lo_r} <= res;
          state <= ST_IDLE;
        end

`ifdef MULDIV_DIV_EN
        ST_DIV: begin
          if (flush) begin
            state    <= ST_IDLE;
            cnt      <= 5'd0;
            div_init <= 1'b0;
          end else if (div_init) begin
            div_init <= 1'b0;
            neg_q    <= div_sgn & (a_r[31] ^ b_r[31]);
            neg_r    <= div_sgn & a_r[31];
            dvz      <= (b_r == 32'd0);
            rem_r    <= 32'd0;
            quo_r    <= mag_a;
            dvs_r    <= mag_b;
          end else begin
            // shift[32] is always 0 when the subtract fails, and a
            // successful difference is below the divisor, so 32 bits suffice
            if (!diff[32]) begin
              rem_r <= diff[31:0];
              quo_r <= {quo_r[30:0], 1'b1};
            end else begin
              rem_r <= shift[31:0];
              quo_r <= {quo_r[30:0], 1'b0};
            end
            cnt <= cnt + 5'd1;
            if (cnt == 5'd31) state <= ST_DFIX;
          end
        end

        ST_DFIX: begin
          if (commit) {hi_r, lo_r} <= res;
          state <= ST_IDLE;
        end
`endif

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_iter.sv
// ---------------------------------------------------------------------------
// tb_muldiv_iter -- directed bench for muldiv_iter.
// A latency-countdown model predicts busy/done/hi/lo each cycle from plain
// 64-bit arithmetic; literal expectations pin the model at key points.
// Build with MULDIV_DIV_EN defined to exercise the divider vectors.
// ---------------------------------------------------------------------------
module tb_muldiv_iter;

  logic                    clk = 1'b0;
  logic                    reset = 1'b1;
  logic                    start = 1'b0;
  selector::muldiv_funct_t funct = selector::NCARE;
  logic [31:0]             rs = 32'd0;
  logic [31:0]             rt = 32'd0;
  logic                    flush = 1'b0;
  logic                    wr_hi = 1'b0;
  logic                    wr_lo = 1'b0;
  logic [31:0]             wdata = 32'd0;
  logic [31:0]             hi;
  logic [31:0]             lo;
  logic                    busy;
  logic                    done;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;

  muldiv_iter dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .funct (funct),
    .rs    (rs),
    .rt    (rt),
    .flush (flush),
    .wr_hi (wr_hi),
    .wr_lo (wr_lo),
    .wdata (wdata),
    .hi    (hi),
    .lo    (lo),
    .busy  (busy),
    .done  (done)
  );

  // ---------------- clock ----------------
  initial forever #5 clk = ~clk;

  // ---------------- checking helper ----------------
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // m_rem counts cycles until the result shows; 0 means idle.
  int          m_rem = 0;
  logic [31:0] m_hi  = 32'd0;
  logic [31:0] m_lo  = 32'd0;
  logic [63:0] m_res = 64'd0;

  function automatic bit op_valid(input selector::muldiv_funct_t f);
    case (f)
      selector::MULT, selector::MULTU, selector::MADD,
      selector::MADDU, selector::MSUB, selector::MSUBU: return 1'b1;
`ifdef MULDIV_DIV_EN
      selector::DIV, selector::DIVU:                    return 1'b1;
`endif
      default:                                          return 1'b0;
    endcase
  endfunction

  function automatic logic [63:0] model_result(input selector::muldiv_funct_t f,
      input logic [31:0] a, input logic [31:0] b, input logic [63:0] hl);
    logic [63:0] sp, up;
    longint      sa, sb, q, r;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    sp = sa * sb;
    up = {32'd0, a} * {32'd0, b};
    case (f)
      selector::MULT:  return sp;
      selector::MULTU: return up;
      selector::MADD:  return hl + sp;
      selector::MADDU: return hl + up;
      selector::MSUB:  return hl - sp;
      selector::MSUBU: return hl - up;
      selector::DIV: begin
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
      end
      selector::DIVU: begin
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        return {a % b, a / b};
      end
      default: return hl;
    endcase
  endfunction

  initial forever begin
    @(posedge clk);
    if (reset) begin
      m_rem = 0;
      m_hi  = 32'd0;
      m_lo  = 32'd0;
    end else if (m_rem > 0) begin
      if (flush) m_rem = 0;
      else if (m_rem == 1) begin
        {m_hi, m_lo} = m_res;
        m_rem = 0;
      end else m_rem--;
    end else if (start && !flush && op_valid(funct)) begin
      m_res = model_result(funct, rs, rt, {m_hi, m_lo});
      m_rem = (funct == selector::DIV || funct == selector::DIVU) ? 34 : 2;
    end else if (!start) begin
      if (wr_hi) m_hi = wdata;
      if (wr_lo) m_lo = wdata;
    end
  end

  // ---------------- per-cycle compare ----------------
  initial forever begin
    @(negedge clk);
    if (chk_en) begin
      logic exp_done;
      exp_done = (m_rem == 1) && !flush && !reset;
      chk("cyc_busy", busy, (m_rem != 0));
      chk("cyc_done", done, exp_done);
      chk("cyc_hi", hi, exp_done ? m_res[63:32] : m_hi);
      chk("cyc_lo", lo, exp_done ? m_res[31:0] : m_lo);
    end
  end

  // ---------------- drivers ----------------
  // poke kinds: 1 re-pulse start, 2 flush, 3 wr_hi, 4 reset (one cycle)
  task automatic run_op(input string nm, input selector::muldiv_funct_t f,
      input logic [31:0] a, input logic [31:0] b, input int exp_lat,
      input int poke_cyc, input int poke_kind,
      input logic [31:0] eh, input logic [31:0] el);
    int got;
    got = 0;
    @(posedge clk); #1;
    funct = f; rs = a; rt = b; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    rs = $urandom; rt = $urandom;   // operands must already be latched
    for (int k = 1; k <= 37; k++) begin
      start = 1'b0; flush = 1'b0; wr_hi = 1'b0; reset = 1'b0;
      if (k == poke_cyc) begin
        case (poke_kind)
          1: start = 1'b1;
          2: flush = 1'b1;
          3: begin wr_hi = 1'b1; wdata = 32'hDEAD_BEEF; end
          4: reset = 1'b1;
          default: ;
        endcase
      end
      @(negedge clk);
      if (done === 1'b1 && got == 0) got = k;
      @(posedge clk); #1;
    end
    start = 1'b0; flush = 1'b0; wr_hi = 1'b0; reset = 1'b0;
    @(negedge clk);
    chk({nm, "_latency"}, got, exp_lat);
    chk({nm, "_hi"}, hi, eh);
    chk({nm, "_lo"}, lo, el);
  endtask

  task automatic write_hl(input logic wh, input logic wl, input logic [31:0] d);
    @(posedge clk); #1;
    wr_hi = wh; wr_lo = wl; wdata = d;
    @(posedge clk); #1;
    wr_hi = 1'b0; wr_lo = 1'b0;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    chk_en = 1'b1;
    @(negedge clk);
    chk("reset_hi", hi, 32'd0);
    chk("reset_lo", lo, 32'd0);
    chk("reset_busy", busy, 1'b0);
    chk("reset_done", done, 1'b0);

    run_op("mult_neg1x2", selector::MULT, 32'hFFFF_FFFF, 32'd2, 2, 0, 0,
           32'hFFFF_FFFF, 32'hFFFF_FFFE);
    run_op("multu_max_x2", selector::MULTU, 32'hFFFF_FFFF, 32'd2, 2, 0, 0,
           32'h0000_0001, 32'hFFFF_FFFE);

    write_hl(1'b1, 1'b1, 32'd0);
    write_hl(1'b0, 1'b1, 32'hFFFF_FFFF);
    @(negedge clk);
    chk("mtlo_hi", hi, 32'd0);
    chk("mtlo_lo", lo, 32'hFFFF_FFFF);

    run_op("maddu_carry", selector::MADDU, 32'd1, 32'd1, 2, 0, 0, 32'd1, 32'd0);
    run_op("msub_borrow", selector::MSUB, 32'd1, 32'd1, 2, 0, 0, 32'd0, 32'hFFFF_FFFF);
    run_op("madd_neg", selector::MADD, 32'hFFFF_FFFE, 32'd3, 2, 0, 0,
           32'd0, 32'hFFFF_FFF9);
    run_op("msubu_wrap", selector::MSUBU, 32'h0001_0000, 32'h0001_0000, 2, 0, 0,
           32'hFFFF_FFFF, 32'hFFFF_FFF9);
    run_op("multu_maxsq", selector::MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 2, 0, 0,
           32'hFFFF_FFFE, 32'h0000_0001);
    run_op("flush_in_acc", selector::MULT, 32'd5, 32'd7, 0, 2, 2,
           32'hFFFF_FFFE, 32'h0000_0001);
    run_op("flush_in_mul", selector::MADD, 32'd5, 32'd7, 0, 1, 2,
           32'hFFFF_FFFE, 32'h0000_0001);
    run_op("wrhi_busy", selector::MULTU, 32'd3, 32'd4, 2, 1, 3, 32'd0, 32'd12);

    write_hl(1'b0, 1'b1, 32'h0000_1234);
    @(negedge clk);
    chk("wrlo_idle_lo", lo, 32'h0000_1234);
    chk("wrlo_idle_hi", hi, 32'd0);

    write_hl(1'b1, 1'b1, 32'hA5A5_A5A5);
    @(negedge clk);
    chk("wr_both_hi", hi, 32'hA5A5_A5A5);
    chk("wr_both_lo", lo, 32'hA5A5_A5A5);

    run_op("ncare", selector::NCARE, 32'd9, 32'd9, 0, 0, 0,
           32'hA5A5_A5A5, 32'hA5A5_A5A5);
    run_op("unlisted", selector::muldiv_funct_t'(4'd13), 32'd9, 32'd9, 0, 0, 0,
           32'hA5A5_A5A5, 32'hA5A5_A5A5);

    // flush and start together in IDLE: start is dropped
    @(posedge clk); #1;
    funct = selector::MULT; rs = 32'd2; rt = 32'd3; start = 1'b1; flush = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; flush = 1'b0;
    @(negedge clk);
    chk("flush_start_busy", busy, 1'b0);
    chk("flush_start_lo", lo, 32'hA5A5_A5A5);

    run_op("reset_mid_madd", selector::MADD, 32'd3, 32'd3, 0, 1, 4, 32'd0, 32'd0);

`ifdef MULDIV_DIV_EN
    run_op("div_m7_2", selector::DIV, 32'hFFFF_FFF9, 32'd2, 34, 10, 1,
           32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_op("divu_by0", selector::DIVU, 32'd100, 32'd0, 34, 0, 0,
           32'd100, 32'hFFFF_FFFF);
    run_op("div_ovf", selector::DIV, 32'h8000_0000, 32'hFFFF_FFFF, 34, 0, 0,
           32'd0, 32'h8000_0000);
    run_op("div_7_m2", selector::DIV, 32'd7, 32'hFFFF_FFFE, 34, 0, 0,
           32'd1, 32'hFFFF_FFFD);
    run_op("divu_max_10", selector::DIVU, 32'hFFFF_FFFF, 32'd10, 34, 0, 0,
           32'd5, 32'h1999_9999);
    run_op("div_neg_by0", selector::DIV, 32'hFFFF_FF9C, 32'd0, 34, 0, 0,
           32'hFFFF_FF9C, 32'hFFFF_FFFF);
    write_hl(1'b1, 1'b0, 32'd5);
    write_hl(1'b0, 1'b1, 32'd6);
    run_op("divu_flush20", selector::DIVU, 32'd1000, 32'd7, 0, 20, 2, 32'd5, 32'd6);
    run_op("div_wrhi_busy", selector::DIV, 32'd1000, 32'd7, 34, 5, 3, 32'd6, 32'd142);
`else
    write_hl(1'b1, 1'b1, 32'h0000_0077);
    run_op("div_disabled", selector::DIV, 32'd10, 32'd3, 0, 0, 0,
           32'h0000_0077, 32'h0000_0077);
    run_op("divu_disabled", selector::DIVU, 32'd10, 32'd3, 0, 0, 0,
           32'h0000_0077, 32'h0000_0077);
`endif

    repeat (2) @(posedge clk);
    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
